// File: rtl/bubble_seq_pkg.sv
// Shared types and constants for the bubble memory access sequencer.
// Optional watchdog is enabled by defining BUBBLE_SEQ_TIMEOUT_EN.
package bubble_seq_pkg;

  localparam int POS_W           = 12;
  localparam int TMO_W           = 24;
  localparam int LOOP_LENGTH_DEF = 2053;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_READ,
    ST_STOP_WAIT,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic shift_n;
    logic repl_n;
    logic ready;
    logic done;
  } seq_out_t;

  function automatic seq_out_t state_outputs(input seq_state_e s);
    seq_out_t o;
    o = '{shift_n: 1'b1, repl_n: 1'b1, ready: 1'b0, done: 1'b0};
    unique case (s)
      ST_IDLE:      o.ready   = 1'b1;
      ST_SEEK:      o.shift_n = 1'b0;
      ST_READ: begin
        o.shift_n = 1'b0;
        o.repl_n  = 1'b0;
      end
      ST_STOP_WAIT: o.shift_n = 1'b1;
      ST_DONE:      o.done    = 1'b1;
      default:      o.ready   = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bubble_position_tracker.sv
// Detects position_change rising edges and tracks the minor-loop
// position modulo LOOP_LENGTH.
module bubble_position_tracker
  import bubble_seq_pkg::*;
#(
  parameter int LOOP_LENGTH = LOOP_LENGTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             position_change,
  output logic             edge_stb,
  output logic [POS_W-1:0] current_position,
  output logic [POS_W-1:0] next_position
);

  logic             pc_q;
  logic [POS_W-1:0] pos_q, pos_d;

  always_comb begin
    edge_stb = position_change & ~pc_q;
    if (pos_q == POS_W'(LOOP_LENGTH - 1))
      next_position = '0;
    else
      next_position = pos_q + POS_W'(1);
    pos_d = edge_stb ? next_position : pos_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= 1'b0;
      pos_q <= '0;
    end else begin
      pc_q  <= position_change;
      pos_q <= pos_d;
    end
  end

  assign current_position = pos_q;

endmodule

// File: rtl/bubble_access_sequencer.sv
// Seek / replicate / stop sequencer for a bubble memory minor loop.
// Define BUBBLE_SEQ_TIMEOUT_EN to add the position_change watchdog.
module bubble_access_sequencer
  import bubble_seq_pkg::*;
#(
  parameter int          LOOP_LENGTH    = LOOP_LENGTH_DEF,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd960000
) (
  input  logic             master_clock,
  input  logic             master_reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_target,
  input  logic [POS_W-1:0] cmd_length,
  input  logic             cmd_bootloop,
  input  logic             abort,
  input  logic             position_change,
  input  logic             bubble_access,
  output logic             bubble_shift_enable,
  output logic             replicator_enable,
  output logic             bootloop_enable,
  output logic [POS_W-1:0] current_position,
  output logic             done,
  output logic             error
);

  logic             edge_stb;
  logic [POS_W-1:0] pos_next;
  logic             tmo;

  seq_state_e       state_q, state_d;
  logic [POS_W-1:0] tgt_q, tgt_d;
  logic [POS_W-1:0] len_q, len_d;
  logic             boot_q, boot_d;
  logic             err_q, err_d;
  logic             boot_en_q, boot_en_d;
  seq_out_t         out_q, out_d;

  bubble_position_tracker #(
    .LOOP_LENGTH(LOOP_LENGTH)
  ) u_tracker (
    .clk             (master_clock),
    .rst_n           (master_reset_n),
    .position_change (position_change),
    .edge_stb        (edge_stb),
    .current_position(current_position),
    .next_position   (pos_next)
  );

`ifdef BUBBLE_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] wd_q, wd_d;
  logic             wd_act;

  // Counts cycles without a position step while the loop is shifting.
  always_comb begin
    wd_act = (state_q == ST_SEEK) || (state_q == ST_READ);
    wd_d   = (wd_act && !edge_stb) ? wd_q + TMO_W'(1) : '0;
    tmo    = wd_act && !edge_stb &&
             (wd_q == TIMEOUT_CYCLES - TMO_W'(1));
  end

  always_ff @(posedge master_clock or negedge master_reset_n) begin
    if (!master_reset_n) wd_q <= '0;
    else                 wd_q <= wd_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    len_d   = len_q;
    boot_d  = boot_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          tgt_d  = cmd_target;
          len_d  = (cmd_length == '0) ? POS_W'(1) : cmd_length;
          boot_d = cmd_bootloop;
          if (int'(cmd_target) >= LOOP_LENGTH) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (current_position == cmd_target) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_SEEK;
          end
        end
      end
      ST_SEEK: begin
        if (abort) begin
          state_d = ST_STOP_WAIT;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = ST_STOP_WAIT;
        end else if (edge_stb && pos_next == tgt_q) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (abort) begin
          state_d = ST_STOP_WAIT;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = ST_STOP_WAIT;
        end else if (edge_stb) begin
          len_d = len_q - POS_W'(1);
          if (len_q == POS_W'(1)) state_d = ST_STOP_WAIT;
        end
      end
      ST_STOP_WAIT: begin
        if (!bubble_access) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pins follow the state being entered, so they change with state_q.
    out_d     = state_outputs(state_d);
    boot_en_d = 1'b0;
    if (state_d == ST_SEEK || state_d == ST_READ ||
        state_d == ST_STOP_WAIT)
      boot_en_d = boot_d;
  end

  always_ff @(posedge master_clock or negedge master_reset_n) begin
    if (!master_reset_n) begin
      state_q   <= ST_IDLE;
      tgt_q     <= '0;
      len_q     <= '0;
      boot_q    <= 1'b0;
      err_q     <= 1'b0;
      boot_en_q <= 1'b0;
      out_q     <= '{shift_n: 1'b1, repl_n: 1'b1,
                     ready: 1'b1, done: 1'b0};
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      len_q     <= len_d;
      boot_q    <= boot_d;
      err_q     <= err_d;
      boot_en_q <= boot_en_d;
      out_q     <= out_d;
    end
  end

  assign cmd_ready           = out_q.ready;
  assign bubble_shift_enable = out_q.shift_n;
  assign replicator_enable   = out_q.repl_n;
  assign done                = out_q.done;
  assign bootloop_enable     = boot_en_q;
  assign error               = err_q;

endmodule

// File: doc/bubble_access_sequencer.md
BUBBLE_ACCESS_SEQUENCER -- requirements
Module: bubble_access_sequencer

Interface
REQ-001 SHALL have parameter LOOP_LENGTH, default 2053, meaning positions per minor-loop revolution.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24'd960000, meaning maximum master_clock cycles between position_change pulses while shifting.
REQ-003 SHALL have port master_clock, input, 1, meaning the 48MHz system clock and the only clock.
REQ-004 SHALL have port master_reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, meaning a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1, meaning a command can be accepted; high only in IDLE.
REQ-007 SHALL have port cmd_target, input, 12, meaning the start position in the range 0..LOOP_LENGTH-1.
REQ-008 SHALL have port cmd_length, input, 12, meaning the number of positions to replicate; a value of 0 is treated as 1.
REQ-009 SHALL have port cmd_bootloop, input, 1, meaning the command accesses the bootloop page.
REQ-010 SHALL have port abort, input, 1, meaning stop the current access.
REQ-011 SHALL have ports position_change and bubble_access, input, 1 each, driven by the timing generator.
REQ-012 SHALL have port bubble_shift_enable, output, 1, active low, meaning shift request.
REQ-013 SHALL have port replicator_enable, output, 1, active low.
REQ-014 SHALL have port bootloop_enable, output, 1, active high.
REQ-015 SHALL have port current_position, output, 12, meaning the tracked loop position.
REQ-016 SHALL have ports done and error, output, 1 each; done is a 1-cycle pulse and error is sticky.

Function
REQ-017 SHALL detect position_change rising edges with a registered copy; one edge equals one position step.
REQ-018 SHALL increment current_position on each edge and wrap LOOP_LENGTH-1 to 0.
REQ-019 SHALL implement states IDLE, SEEK, READ, STOP_WAIT and DONE.
REQ-020 IDLE: on cmd_valid&cmd_ready, SHALL latch target, length and bootloop; the next state is READ if current_position==target, else SEEK.
REQ-021 SEEK: SHALL drive bubble_shift_enable=0 and replicator_enable=1; on the edge that makes current_position==target, SHALL go to READ.
REQ-022 READ: SHALL drive bubble_shift_enable=0 and replicator_enable=0, and decrement the length counter on each edge; when it reaches 0, SHALL go to STOP_WAIT.
REQ-023 STOP_WAIT: SHALL drive bubble_shift_enable=1 and replicator_enable=1; when bubble_access is low, SHALL go to DONE.
REQ-024 DONE: SHALL assert done for one cycle, then go to IDLE.
REQ-025 bootloop_enable SHALL equal the latched cmd_bootloop from acceptance until DONE, and SHALL be 0 in IDLE.
REQ-026 abort in SEEK or READ SHALL go to STOP_WAIT the next cycle; abort is ignored in IDLE, STOP_WAIT and DONE.
REQ-027 When abort coincides with the final READ edge, the result SHALL be STOP_WAIT (identical either way).
REQ-028 cmd_target >= LOOP_LENGTH SHALL set error and go straight to DONE without shifting.
REQ-029 All outputs SHALL be registered, giving a 1-cycle latency from state change to pins.

Reset
REQ-030 Reset SHALL set: state IDLE, bubble_shift_enable=1, replicator_enable=1, bootloop_enable=0, current_position=0, done=0, error=0, cmd_ready=1 after release.
REQ-031 Reset mid-access SHALL stop shifting immediately with no done pulse.

Configuration
REQ-032 Macro BUBBLE_SEQ_TIMEOUT_EN, when defined, SHALL enable a watchdog that counts cycles since the last edge in SEEK or READ.
REQ-033 Reaching TIMEOUT_CYCLES SHALL set error and go to STOP_WAIT.
REQ-034 Without the macro, the watchdog counter SHALL be absent and error SHALL only report a bad target.

Structure
REQ-035 Shared package bubble_seq_pkg SHALL hold the state enum, POS_W=12, and the LOOP_LENGTH default.
REQ-036 Sub-module bubble_position_tracker SHALL contain the edge detector and the modulo position counter, and output an edge strobe and current_position.

Verification
REQ-037 From reset: cmd target=5, length=3, and 8 position_change pulses -> SEEK for 5 edges, replicator_enable low for exactly 3 edges, done after bubble_access falls, current_position=8.
REQ-038 Wrap: current_position=2052, target=1 -> position goes 2052, 0, 1 and READ begins on the edge to 1.
REQ-039 target==current_position at accept -> READ on the next cycle with no SEEK.
REQ-040 abort asserted on the 2nd READ edge of length=10 -> shift released and done after bubble_access low; error=0.
REQ-041 target=3000 -> error=1 and done pulse; bubble_shift_enable stays 1.
REQ-042 With BUBBLE_SEQ_TIMEOUT_EN defined and no pulses for TIMEOUT_CYCLES in SEEK -> error=1, STOP_WAIT, then done.
